muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/rv32i_types.sv | 38 +++
 rtl/muldiv_datapath.sv | 113 +++++++++++
 rtl/muldiv_sequencer.sv | 108 ++++++++++
 tb/tb_muldiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32 types: M-extension op encoding and the mul/div sequencer states.
// Also holds small helpers for operand signedness and magnitude extraction.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } m_funct3_t;

    function automatic logic rs1_is_signed(input m_funct3_t op);
        return (op == mul) || (op == mulh) || (op == mulhsu) ||
               (op == div) || (op == rem);
    endfunction

    function automatic logic rs2_is_signed(input m_funct3_t op);
        return (op == mul) || (op == mulh) ||
               (op == div) || (op == rem);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v,
                                              input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative RV32M datapath: one 64-bit accumulator shared by the shift-add
// multiplier (product) and the restoring divider ({remainder, quotient}),
// driven through one 34-bit step adder. Sign correction is applied on output.
// Ports: clk, rst (sync, active-high); load_i latches a new op from rs1_i,
// rs2_i, funct3_i; early_i preloads the divide-by-zero answer; step_i runs
// one iteration; result_o is the sign-corrected RV32M result.
module muldiv_datapath
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        early_i,
    input  logic        step_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o
);

    m_funct3_t   op_q, op_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;

    m_funct3_t   op_in;
    logic        s1, s2;
    logic [31:0] a_mag, b_mag;

    logic        is_div;
    logic [33:0] add_a, add_b, sum;

    logic [63:0] prod;
    logic [31:0] quo, rmd;

    assign op_in = m_funct3_t'(funct3_i);
    assign s1    = rs1_is_signed(op_in) & rs1_i[31];
    assign s2    = rs2_is_signed(op_in) & rs2_i[31];
    assign a_mag = magnitude(rs1_i, s1);
    assign b_mag = magnitude(rs2_i, s2);

    // Divide: subtract divisor from {rem, next dividend bit}; bit 33 is
    // the borrow. Multiply: add multiplicand to the upper product half.
    assign is_div = op_q[2];
    assign add_a  = is_div ? {1'b0, acc_q[63:31]} : {2'b00, acc_q[63:32]};
    assign add_b  = is_div ? ~{2'b00, b_q} : {2'b00, b_q};
    assign sum    = add_a + add_b + {33'd0, is_div};

    always_comb begin
        op_d   = op_q;
        b_d    = b_q;
        acc_d  = acc_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (load_i) begin
            op_d   = op_in;
            b_d    = b_mag;
            rneg_d = s1;
            // A zero divisor yields an all-ones quotient, which must not
            // be negated.
            neg_d  = op_in[2] ? ((s1 ^ s2) & (rs2_i != 32'd0)) : (s1 ^ s2);
            if (early_i && (rs2_i == 32'd0))
                acc_d = {a_mag, 32'hFFFF_FFFF};
            else
                acc_d = {32'd0, a_mag};
        end else if (step_i) begin
            if (is_div) begin
                if (!sum[33])
                    acc_d = {sum[31:0], acc_q[30:0], 1'b1};
                else
                    acc_d = {acc_q[62:0], 1'b0};
            end else begin
                if (acc_q[0])
                    acc_d = {sum[32:0], acc_q[31:1]};
                else
                    acc_d = {1'b0, acc_q[63:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= mul;
            b_q    <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    assign prod = neg_q ? (64'd0 - acc_q) : acc_q;
    assign quo  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rmd  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        result_o = '0;
        case (op_q)
            mul:                 result_o = prod[31:0];
            mulh, mulhsu, mulhu: result_o = prod[63:32];
            div, divu:           result_o = quo;
            rem, remu:           result_o = rmd;
            default:             result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, 5-bit iteration counter, stall and done.
// Ports: clk, rst (sync active-high), start/funct3/rs1_data/rs2_data from EX,
// flush squashes the op; stall holds the pipe, done pulses with result.
// Option MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in
// one cycle instead of running all 32 iterations.
module muldiv_sequencer
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_t state_q;
    logic [4:0]    cnt_q;
    logic          done_q;
    logic [31:0]   result_q;

    logic          go;
    logic          early;
    logic          step;
    logic [31:0]   dp_result;

    assign go = (state_q == IDLE) & start & ~flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = funct3[2] &
                   ((rs2_data == 32'd0) |
                    (~funct3[0] &
                     (rs1_data == 32'h8000_0000) &
                     (rs2_data == 32'hFFFF_FFFF)));
`else
    assign early = 1'b0;
`endif

    assign step = ((state_q == MUL) | (state_q == DIV)) & ~flush;

    muldiv_datapath u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (go),
        .early_i  (early),
        .step_i   (step),
        .funct3_i (funct3),
        .rs1_i    (rs1_data),
        .rs2_i    (rs2_data),
        .result_o (dp_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cnt_q <= '0;
                        if (early) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (funct3[2]) begin
                            state_q <= DIV;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // Same instruction still sits in EX: start is ignored.
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    result_q <= dp_result;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stall  = go | (state_q == MUL) | (state_q == DIV);
    assign done   = done_q;
    assign result = done_q ? dp_result : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, random
// ops against an arithmetic reference, flush/reset aborts and back-to-back.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit early_en;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    function automatic logic [31:0] ref_m(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (early_en && f[2] && ((b == 0) || (!f[0] && ovf)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op, holds start while stalled (operands scrambled to
    // prove they are not re-sampled) and checks latency, stall and result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input string nm,
                          input bit no_wait);
        logic [31:0] exp;
        int lat, n;
        bit got, stall_ok;
        exp = ref_m(f, a, b);
        lat = exp_lat(f, a, b);
        if (!no_wait) @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        #1;
        stall_ok = (stall === 1'b1);
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) got = 1;
            else begin
                if (stall !== 1'b1) stall_ok = 0;
                rs1_data = $urandom;
                rs2_data = $urandom;
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: done not seen in %0d cycles", nm, n);
            return;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h want %h (f=%0d a=%h b=%h)",
                     nm, result, exp, f, a, b);
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL %s stall_busy: got 0 want 1 before done", nm);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_done: got %b want 0", nm, stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0;
        funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd6;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: stall=%b done=%b want 0 0", stall, done);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", result);
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3", 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff", 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0);
        run_op(3'd5, 32'd100, 32'd7, "divu_100_7", 0);
        run_op(3'd5, 32'd5, 32'd0, "divu_by0", 0);
        run_op(3'd7, 32'd5, 32'd0, "remu_by0", 0);
        run_op(3'd6, 32'hFFFF_FFF0, 32'd0, "rem_neg_by0", 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu_neg", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, "random", 0);
        end
    endtask

    task automatic test_abort(input bit use_rst, input string nm);
        bit saw_done;
        saw_done = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0;
        rs1_data = $urandom; rs2_data = $urandom;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        start = 1'b0;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s abort_ctl: stall=%b done=%b want 0 0",
                     nm, stall, done);
        end
        if (use_rst) begin
            checks++;
            if (result !== 32'd0) begin
                errors++;
                $display("FAIL %s abort_result: got %h want 0", nm, result);
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL %s abort_done: got done pulse want none", nm);
        end
        run_op(3'd0, 32'd3, 32'd4, nm, 1);
    endtask

    task automatic test_flush_vs_start();
        bit saw;
        saw = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5;
        rs1_data = 32'd9; rs2_data = 32'd3;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start stall: got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || stall === 1'b1) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL flush_start activity: got busy/done want idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp;
        a = $urandom; b = $urandom;
        exp = ref_m(3'd1, a, b);
        run_op(3'd1, a, b, "b2b_first", 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL b2b_hold: done=%b result=%h want 0 %h",
                     done, result, exp);
        end
        run_op(3'd7, 32'd1000, 32'd33, "b2b_second", 1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "b2b_third", 0);
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL b2b_idle_hold: got %h want 80000000", result);
        end
    endtask

    initial begin
`ifdef MULDIV_EARLY_OUT_EN
        early_en = 1'b1;
`else
        early_en = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_abort(0, "flush_abort");
        test_abort(1, "rst_abort");
        test_flush_vs_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
